// File: rtl/turn_sequencer_if.sv
// Turn-sequencer bus: debounced game requests in, turn status and pulses out.
interface turn_sequencer_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned MAX_TURNS   = 9
) ();
  localparam int unsigned PW = $clog2(NUM_PLAYERS);
  localparam int unsigned TW = $clog2(MAX_TURNS + 1);

  logic          select;
  logic          cell_free;
  logic          game_over;
  logic          new_game;
  logic [PW-1:0] cur_player;
  logic [TW-1:0] turn_count;
  logic          move_accept;
  logic          move_reject;
  logic          timeout;
  logic          halted;
  logic          board_full;

  // Request side: debouncers, cell decoder and board logic.
  modport master (
    output select, cell_free, game_over, new_game,
    input  cur_player, turn_count, move_accept, move_reject, timeout, halted, board_full
  );

  // Sequencer side.
  modport slave (
    input  select, cell_free, game_over, new_game,
    output cur_player, turn_count, move_accept, move_reject, timeout, halted, board_full
  );
endinterface

// File: rtl/turn_sequencer.sv
// N-player turn controller: edge-detected select, move validation, idle-turn
// timeout, turn counting with board-full halt, and rotating new-game starter.
module turn_sequencer #(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned FIRST_PLAYER   = 0,
  parameter int unsigned MAX_TURNS      = 9,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  turn_sequencer_if.slave   bus
);
  localparam int unsigned PW      = $clog2(NUM_PLAYERS);
  localparam int unsigned TW      = $clog2(MAX_TURNS + 1);
  // Timer keeps one bit when timeout is disabled so the logic stays well formed.
  localparam int unsigned CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {
    PLAY,
    HALT
  } state_t;

  state_t        state_q, state_d;
  logic          select_q, select_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [PW-1:0] starter_q, starter_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          full_q, full_d;
  logic          accept_q, accept_d;
  logic          reject_q, reject_d;
  logic          timeout_q, timeout_d;
  logic          sel_edge;
  logic [TW-1:0] cnt_inc;

  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    return (p == PW'(NUM_PLAYERS - 1)) ? '0 : p + PW'(1);
  endfunction

  // State and output registers; select history resets high so a held select never fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PLAY;
      select_q  <= 1'b1;
      cur_q     <= PW'(FIRST_PLAYER);
      starter_q <= PW'(FIRST_PLAYER);
      cnt_q     <= '0;
      timer_q   <= '0;
      full_q    <= 1'b0;
      accept_q  <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      cur_q     <= cur_d;
      starter_q <= starter_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      full_q    <= full_d;
      accept_q  <= accept_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: new_game > game_over > accept > reject > timeout > timer tick.
  always_comb begin
    state_d   = state_q;
    select_d  = bus.select;
    cur_d     = cur_q;
    starter_d = starter_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    full_d    = full_q;
    accept_d  = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    sel_edge  = bus.select & ~select_q;
    cnt_inc   = cnt_q + TW'(1);

    if (bus.new_game) begin
      starter_d = next_player(starter_q);
      cur_d     = next_player(starter_q);
      cnt_d     = '0;
      timer_d   = '0;
      full_d    = 1'b0;
      state_d   = PLAY;
    end else if (state_q == PLAY) begin
      if (bus.game_over) begin
        state_d = HALT;
      end else if (sel_edge && bus.cell_free) begin
        accept_d = 1'b1;
        cnt_d    = cnt_inc;
        timer_d  = '0;
        // The final move halts the game and leaves the last mover as cur_player.
        if (cnt_inc == TW'(MAX_TURNS)) begin
          state_d = HALT;
          full_d  = 1'b1;
        end else begin
          cur_d = next_player(cur_q);
        end
      end else if (sel_edge) begin
        reject_d = 1'b1;
      end else if (TIMEOUT_CYCLES > 0) begin
        if (timer_q == CW'(TO_LAST)) begin
          timeout_d = 1'b1;
          cur_d     = next_player(cur_q);
          timer_d   = '0;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
    end
  end

  assign bus.cur_player  = cur_q;
  assign bus.turn_count  = cnt_q;
  assign bus.move_accept = accept_q;
  assign bus.move_reject = reject_q;
  assign bus.timeout     = timeout_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.board_full  = full_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: a 3-player instance without timeout and a 2-player
// instance with a 4-cycle timeout, each checked against a behavioural model.
module tb_turn_sequencer;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  turn_sequencer_if #(.NUM_PLAYERS(3), .MAX_TURNS(9)) if_a ();
  turn_sequencer_if #(.NUM_PLAYERS(2), .MAX_TURNS(9)) if_b ();

  turn_sequencer #(.NUM_PLAYERS(3), .FIRST_PLAYER(0), .MAX_TURNS(9), .TIMEOUT_CYCLES(0))
    dut_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));
  turn_sequencer #(.NUM_PLAYERS(2), .FIRST_PLAYER(0), .MAX_TURNS(9), .TIMEOUT_CYCLES(4))
    dut_b (.clk(clk), .reset(rst_b), .bus(if_b.slave));

  typedef struct packed {
    logic [3:0] cur;
    logic [3:0] cnt;
    logic       acc;
    logic       rej;
    logic       to;
    logic       hlt;
    logic       full;
  } obs_t;

  typedef struct {
    bit halt;
    bit full;
    int cur;
    int cnt;
    int timer;
    int starter;
    bit selp;
  } mst_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  obs_t last;
  mst_t ma, mb;
  int n_checks = 0;
  int n_errors = 0;

  task automatic model_reset(output mst_t m);
    m.halt = 0; m.full = 0; m.cur = 0; m.cnt = 0;
    m.timer = 0; m.starter = 0; m.selp = 1;
  endtask

  // Behavioural turn model evaluated once per clock edge.
  task automatic model_step(inout mst_t m, input int np, input int maxt, input int tmo,
                            input bit sel, input bit free, input bit go, input bit ng,
                            output obs_t e);
    bit rise;
    e = '0;
    rise = sel && !m.selp;
    m.selp = sel;
    if (ng) begin
      m.starter = (m.starter + 1) % np;
      m.cur = m.starter; m.cnt = 0; m.timer = 0; m.halt = 0; m.full = 0;
    end else if (!m.halt) begin
      if (go) m.halt = 1;
      else if (rise && free) begin
        e.acc = 1; m.cnt++; m.timer = 0;
        if (m.cnt == maxt) begin m.halt = 1; m.full = 1; end
        else m.cur = (m.cur + 1) % np;
      end else if (rise) e.rej = 1;
      else if (tmo > 0) begin
        if (m.timer == tmo - 1) begin e.to = 1; m.cur = (m.cur + 1) % np; m.timer = 0; end
        else m.timer++;
      end
    end
    e.cur = 4'(m.cur); e.cnt = 4'(m.cnt); e.hlt = m.halt; e.full = m.full;
  endtask

  function automatic obs_t obs_a();
    obs_t o;
    o.cur = 4'(if_a.cur_player); o.cnt = 4'(if_a.turn_count);
    o.acc = if_a.move_accept; o.rej = if_a.move_reject; o.to = if_a.timeout;
    o.hlt = if_a.halted; o.full = if_a.board_full;
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.cur = 4'(if_b.cur_player); o.cnt = 4'(if_b.turn_count);
    o.acc = if_b.move_accept; o.rej = if_b.move_reject; o.to = if_b.timeout;
    o.hlt = if_b.halted; o.full = if_b.board_full;
    return o;
  endfunction

  task automatic tick_a(input bit sel, input bit free, input bit go, input bit ng);
    obs_t e;
    if_a.select = sel; if_a.cell_free = free; if_a.game_over = go; if_a.new_game = ng;
    model_step(ma, 3, 9, 0, sel, free, go, ng, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    last = obs_a();
    obs_q.push_back(last);
  endtask

  task automatic tick_b(input bit sel, input bit free, input bit go, input bit ng);
    obs_t e;
    if_b.select = sel; if_b.cell_free = free; if_b.game_over = go; if_b.new_game = ng;
    model_step(mb, 2, 9, 4, sel, free, go, ng, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    last = obs_b();
    obs_q.push_back(last);
  endtask

  task automatic test_reset();
    obs_t e, o;
    if_a.select = 0; if_a.cell_free = 1; if_a.game_over = 0; if_a.new_game = 0;
    if_b.select = 0; if_b.cell_free = 1; if_b.game_over = 0; if_b.new_game = 0;
    #2;
    n_checks++;
    if (obs_a() !== obs_t'(0)) begin
      n_errors++; $display("FAIL reset_a: got %h expected %h", obs_a(), obs_t'(0));
    end
    n_checks++;
    if (obs_b() !== obs_t'(0)) begin
      n_errors++; $display("FAIL reset_b: got %h expected %h", obs_b(), obs_t'(0));
    end
    @(posedge clk); #1;
    rst_a = 0; model_reset(ma);
    tick_a(0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_rotation();
    obs_t e, o;
    logic [3:0] seq [3];
    int acc_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick_a(1, 1, 0, 0);
      seq[i] = last.cur;
      if (last.acc) acc_n++;
      for (int j = 0; j < 3; j++) begin
        tick_a(0, 1, 0, 0);
        if (last.acc) acc_n++;
      end
    end
    n_checks++;
    if (seq[0] !== 4'd1 || seq[1] !== 4'd2 || seq[2] !== 4'd0) begin
      n_errors++; $display("FAIL rotation_order: got %0d,%0d,%0d expected 1,2,0", seq[0], seq[1], seq[2]);
    end
    n_checks++;
    if (last.cnt !== 4'd3 || acc_n != 3) begin
      n_errors++; $display("FAIL rotation_count: got count %0d accepts %0d expected 3 and 3", last.cnt, acc_n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL rotation_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reject_hold();
    obs_t e, o;
    int acc_n = 0;
    tick_a(1, 0, 0, 0);
    n_checks++;
    if (last.rej !== 1'b1 || last.cur !== 4'd0 || last.cnt !== 4'd3) begin
      n_errors++; $display("FAIL reject_pulse: got rej %b cur %0d cnt %0d expected 1 0 3", last.rej, last.cur, last.cnt);
    end
    tick_a(0, 0, 0, 0);
    n_checks++;
    if (last.rej !== 1'b0) begin
      n_errors++; $display("FAIL reject_width: got %b expected 0", last.rej);
    end
    for (int i = 0; i < 5; i++) begin
      tick_a(1, 1, 0, 0);
      if (last.acc) acc_n++;
    end
    tick_a(0, 1, 0, 0);
    n_checks++;
    if (acc_n != 1 || last.cur !== 4'd1 || last.cnt !== 4'd4) begin
      n_errors++; $display("FAIL held_select: got accepts %0d cur %0d cnt %0d expected 1 1 4", acc_n, last.cur, last.cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reject_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_priority();
    obs_t e, o;
    tick_a(1, 1, 1, 0);
    n_checks++;
    if (last.hlt !== 1'b1 || last.acc !== 1'b0 || last.cnt !== 4'd4) begin
      n_errors++; $display("FAIL gameover_prio: got hlt %b acc %b cnt %0d expected 1 0 4", last.hlt, last.acc, last.cnt);
    end
    tick_a(0, 1, 0, 0);
    tick_a(1, 1, 0, 0);
    n_checks++;
    if (last.acc !== 1'b0 || last.rej !== 1'b0 || last.cnt !== 4'd4) begin
      n_errors++; $display("FAIL halt_ignore: got acc %b rej %b cnt %0d expected 0 0 4", last.acc, last.rej, last.cnt);
    end
    tick_a(0, 1, 0, 0);
    tick_a(1, 1, 0, 1);
    n_checks++;
    if (last.acc !== 1'b0 || last.cur !== 4'd1 || last.cnt !== 4'd0 || last.hlt !== 1'b0) begin
      n_errors++; $display("FAIL newgame_prio: got acc %b cur %0d cnt %0d hlt %b expected 0 1 0 0",
                           last.acc, last.cur, last.cnt, last.hlt);
    end
    tick_a(0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL priority_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    logic [3:0] to_seq;
    rst_a = 1;
    rst_b = 0; model_reset(mb);
    for (int i = 0; i < 4; i++) begin
      tick_b(0, 1, 0, 0);
      to_seq[i] = last.to;
    end
    n_checks++;
    if (to_seq !== 4'b1000 || last.cur !== 4'd1 || last.cnt !== 4'd0) begin
      n_errors++; $display("FAIL timeout_first: got seq %b cur %0d cnt %0d expected 1000 1 0", to_seq, last.cur, last.cnt);
    end
    tick_b(0, 1, 0, 0);
    tick_b(0, 1, 0, 0);
    tick_b(1, 1, 0, 0);
    n_checks++;
    if (last.acc !== 1'b1 || last.to !== 1'b0 || last.cur !== 4'd0) begin
      n_errors++; $display("FAIL timeout_accept: got acc %b to %b cur %0d expected 1 0 0", last.acc, last.to, last.cur);
    end
    for (int i = 0; i < 4; i++) begin
      tick_b(0, 1, 0, 0);
      to_seq[i] = last.to;
    end
    n_checks++;
    if (to_seq !== 4'b1000 || last.cur !== 4'd1 || last.cnt !== 4'd1) begin
      n_errors++; $display("FAIL timeout_restart: got seq %b cur %0d cnt %0d expected 1000 1 1", to_seq, last.cur, last.cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL timeout_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_board_full();
    obs_t e, o;
    int pulses = 0;
    rst_b = 1;
    @(posedge clk); #1;
    rst_b = 0; model_reset(mb);
    tick_b(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick_b(1, 1, 0, 0);
      if (i == 8) begin
        n_checks++;
        if (last.full !== 1'b1 || last.hlt !== 1'b1 || last.cur !== 4'd0 || last.cnt !== 4'd9 || last.acc !== 1'b1) begin
          n_errors++; $display("FAIL board_full: got full %b hlt %b cur %0d cnt %0d acc %b expected 1 1 0 9 1",
                               last.full, last.hlt, last.cur, last.cnt, last.acc);
        end
      end
      tick_b(0, 1, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick_b(0, 1, 0, 0);
      pulses += int'(last.acc) + int'(last.rej) + int'(last.to);
    end
    tick_b(1, 1, 0, 0);
    pulses += int'(last.acc) + int'(last.rej) + int'(last.to);
    tick_b(0, 1, 0, 0);
    n_checks++;
    if (pulses != 0 || last.cnt !== 4'd9) begin
      n_errors++; $display("FAIL full_silent: got pulses %0d cnt %0d expected 0 9", pulses, last.cnt);
    end
    tick_b(0, 1, 0, 1);
    n_checks++;
    if (last.cur !== 4'd1 || last.full !== 1'b0 || last.hlt !== 1'b0 || last.cnt !== 4'd0) begin
      n_errors++; $display("FAIL full_restart: got cur %0d full %b hlt %b cnt %0d expected 1 0 0 0",
                           last.cur, last.full, last.hlt, last.cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL board_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset_midgame();
    obs_t e, o;
    int acc_n = 0;
    rst_b = 1;
    rst_a = 0; model_reset(ma);
    tick_a(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick_a(1, 1, 0, 0);
      tick_a(0, 1, 0, 0);
    end
    n_checks++;
    if (last.cur !== 4'd1 || last.cnt !== 4'd4) begin
      n_errors++; $display("FAIL midgame_setup: got cur %0d cnt %0d expected 1 4", last.cur, last.cnt);
    end
    #3 rst_a = 1;
    #1;
    n_checks++;
    if (obs_a() !== obs_t'(0)) begin
      n_errors++; $display("FAIL async_reset: got %h expected %h", obs_a(), obs_t'(0));
    end
    model_reset(ma);
    if_a.select = 1;
    @(posedge clk); #1;
    rst_a = 0;
    for (int i = 0; i < 3; i++) begin
      tick_a(1, 1, 0, 0);
      if (last.acc) acc_n++;
    end
    n_checks++;
    if (acc_n != 0 || last.cnt !== 4'd0) begin
      n_errors++; $display("FAIL held_through_reset: got accepts %0d cnt %0d expected 0 0", acc_n, last.cnt);
    end
    tick_a(0, 1, 0, 0);
    tick_a(1, 1, 0, 0);
    tick_a(0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL midgame_sb: got %h expected %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_reject_hold();
    test_priority();
    test_timeout();
    test_board_full();
    test_reset_midgame();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end
endmodule
